// File: rtl/result_buffer.sv
// result_buffer: packs pairs of 32-bit array results into 64-bit words, queues them, and drives a registered valid/ready output
module result_buffer #(
    parameter int QUEUE_DEPTH  = 64,
    parameter int ADDR_WIDTH   = 6,
    parameter int RESULT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [RESULT_WIDTH-1:0]   result_in,
    input  logic                      result_valid,
    input  logic                      result_last,
    output logic                      result_ready,
    output logic [2*RESULT_WIDTH-1:0] interface_output,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      buffer_full,
    output logic                      buffer_empty,
    output logic [ADDR_WIDTH:0]       count
);
    typedef enum logic {LOW_EMPTY, LOW_HELD} state_t;
    state_t state, state_next;
    logic [RESULT_WIDTH-1:0] low_half;
    logic [2*RESULT_WIDTH-1:0] queue [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] head, tail;
    logic accept, push, pop, latch_low;
    logic [2*RESULT_WIDTH-1:0] push_word;
    assign buffer_full  = count == (ADDR_WIDTH+1)'(QUEUE_DEPTH);
    assign buffer_empty = count == '0 && !out_valid;
    // Gated on full even when only latching a low half, so the packer never strands a word
    assign result_ready = !buffer_full;
    assign accept       = result_valid & result_ready;
    assign pop          = count != '0 && (!out_valid || out_ready);
    always_ff @(posedge clk)
        if (rst) state <= LOW_EMPTY;
        else     state <= state_next;
    always_comb
        state_next = !accept ? state : (state == LOW_HELD || result_last) ? LOW_EMPTY : LOW_HELD;
    always_comb begin
        push      = accept && (state == LOW_HELD || result_last);
        latch_low = accept && state == LOW_EMPTY && !result_last;
        push_word = state == LOW_HELD ? {result_in, low_half} : {{RESULT_WIDTH{1'b0}}, result_in};
    end
    always_ff @(posedge clk)
        if (push) queue[tail] <= push_word;
    always_ff @(posedge clk) begin
        if (rst) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            low_half         <= '0;
            interface_output <= '0;
            out_valid        <= 1'b0;
        end else begin
            if (latch_low) low_half <= result_in;
            if (push) tail <= tail + 1'b1;
            if (pop) begin
                head             <= head + 1'b1;
                interface_output <= queue[head];
                out_valid        <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            count <= count + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
        end
    end
endmodule

// File: tb/tb_result_buffer.sv
// tb_result_buffer: randomized bench comparing result_buffer against a queue-based reference model
module tb_result_buffer;
    logic        clk = 0;
    logic        rst = 0;
    logic [31:0] result_in = '0;
    logic        result_valid = 0;
    logic        result_last = 0;
    logic        result_ready;
    logic [63:0] interface_output;
    logic        out_valid;
    logic        out_ready = 0;
    logic        buffer_full;
    logic        buffer_empty;
    logic [6:0]  count;
    int checks = 0;
    int errors = 0;
    bit [63:0] mq[$];
    logic [63:0] m_out;
    bit m_ov, m_held;
    bit [31:0] m_low;
    always #5 clk = ~clk;
    result_buffer dut (
        .clk(clk), .rst(rst), .result_in(result_in), .result_valid(result_valid),
        .result_last(result_last), .result_ready(result_ready),
        .interface_output(interface_output), .out_valid(out_valid), .out_ready(out_ready),
        .buffer_full(buffer_full), .buffer_empty(buffer_empty), .count(count)
    );
    task automatic do_reset;
        rst = 1; result_valid = 0; result_last = 0; out_ready = 0;
        @(posedge clk); #1;
        rst = 0;
        mq.delete(); m_out = '0; m_ov = 0; m_held = 0; m_low = '0;
    endtask
    // One clock of stimulus; the model applies the same rules to queues
    task automatic cyc(input bit v, input bit l, input logic [31:0] d, input bit ordy);
        bit acc, pp;
        result_valid = v; result_last = l; result_in = d; out_ready = ordy;
        acc = v && mq.size() < 64;
        pp = mq.size() > 0 && (!m_ov || ordy);
        @(posedge clk); #1;
        if (pp) begin m_out = mq.pop_front(); m_ov = 1; end
        else if (ordy) m_ov = 0;
        if (acc) begin
            if (m_held) begin mq.push_back({d, m_low}); m_held = 0; end
            else if (l) mq.push_back({32'h0, d});
            else begin m_low = d; m_held = 1; end
        end
    endtask
    task automatic test_reset;
        do_reset();
        checks++;
        if (interface_output !== 64'h0 || out_valid !== 1'b0 || result_ready !== 1'b1 ||
            buffer_full !== 1'b0 || buffer_empty !== 1'b1 || count !== 7'd0) begin
            errors++;
            $display("FAIL reset: out=%h valid=%b ready=%b full=%b empty=%b count=%0d, need 0 0 1 0 1 0",
                     interface_output, out_valid, result_ready, buffer_full, buffer_empty, count);
        end
    endtask
    task automatic test_pair;
        do_reset();
        cyc(1, 0, 32'h11111111, 1);
        cyc(1, 0, 32'h22222222, 1);
        checks++;
        if (out_valid !== 1'b0 || count !== 7'd1) begin
            errors++; $display("FAIL pair_e2: valid=%b count=%0d, need 0 1", out_valid, count);
        end
        cyc(0, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b1 || interface_output !== 64'h22222222_11111111 || count !== 7'd0) begin
            errors++; $display("FAIL pair_e3: valid=%b out=%h count=%0d, need 1 2222222211111111 0", out_valid, interface_output, count);
        end
        cyc(0, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b0 || buffer_empty !== 1'b1 || count !== 7'd0) begin
            errors++; $display("FAIL pair_drained: valid=%b empty=%b count=%0d, need 0 1 0", out_valid, buffer_empty, count);
        end
    endtask
    task automatic test_odd;
        logic [63:0] got[$];
        do_reset();
        cyc(1, 0, 32'hA, 1);
        if (out_valid) got.push_back(interface_output);
        cyc(1, 0, 32'hB, 1);
        if (out_valid) got.push_back(interface_output);
        cyc(1, 1, 32'hC, 1);
        if (out_valid) got.push_back(interface_output);
        repeat (4) begin
            cyc(0, 0, 0, 1);
            if (out_valid) got.push_back(interface_output);
        end
        checks++;
        if (got.size() != 2) begin
            errors++; $display("FAIL odd_count: words=%0d, need 2", got.size());
        end else begin
            checks++;
            if (got[0] !== 64'h0000000B_0000000A || got[1] !== 64'h00000000_0000000C) begin
                errors++; $display("FAIL odd_words: %h %h, need 0000000b0000000a 000000000000000c", got[0], got[1]);
            end
        end
    endtask
    task automatic test_fill;
        logic [31:0] r0, r1;
        do_reset();
        r0 = $urandom; r1 = $urandom;
        cyc(1, 0, r0, 0);
        cyc(1, 0, r1, 0);
        for (int i = 2; i < 130; i++) begin
            cyc(1, 0, $urandom, 0);
            checks++;
            if (out_valid !== 1'b1 || interface_output !== {r1, r0} || count !== 7'(mq.size())) begin
                errors++;
                $display("FAIL fill_%0d: valid=%b out=%h count=%0d, need 1 %h %0d", i, out_valid, interface_output, count, {r1, r0}, mq.size());
            end
        end
        checks++;
        if (count !== 7'd64 || buffer_full !== 1'b1 || result_ready !== 1'b0 || buffer_empty !== 1'b0) begin
            errors++; $display("FAIL fill_full: count=%0d full=%b ready=%b empty=%b, need 64 1 0 0", count, buffer_full, result_ready, buffer_empty);
        end
        cyc(1, 0, $urandom, 0);
        checks++;
        if (count !== 7'd64 || result_ready !== 1'b0 || interface_output !== {r1, r0} || m_held) begin
            errors++; $display("FAIL fill_blocked: count=%0d ready=%b out=%h, need 64 0 %h", count, result_ready, interface_output, {r1, r0});
        end
    endtask
    task automatic test_full_pop;
        cyc(1, 0, $urandom, 1);
        checks++;
        if (count !== 7'd63 || result_ready !== 1'b1 || buffer_full !== 1'b0 || out_valid !== 1'b1 || interface_output !== m_out) begin
            errors++; $display("FAIL full_pop: count=%0d ready=%b full=%b out=%h, need 63 1 0 %h", count, result_ready, buffer_full, interface_output, m_out);
        end
        cyc(1, 0, $urandom, 1);
        cyc(1, 0, $urandom, 1);
        checks++;
        if (count !== 7'd62 || count !== 7'(mq.size()) || interface_output !== m_out) begin
            errors++; $display("FAIL push_pop_same: count=%0d out=%h, need 62 %h", count, interface_output, m_out);
        end
    endtask
    task automatic test_drain;
        int delivered = 0;
        int n = 0;
        bit o;
        while (delivered < 200 && n < 5000) begin
            o = 1'($urandom_range(0, 1));
            if (m_ov && o) delivered++;
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom, o);
            n++;
            checks++;
            if (count !== 7'(mq.size()) || out_valid !== m_ov || result_ready !== (mq.size() < 64) || (m_ov && interface_output !== m_out)) begin
                errors++;
                $display("FAIL drain_%0d: count=%0d/%0d valid=%b/%b ready=%b word=%h/%h",
                         n, count, mq.size(), out_valid, m_ov, result_ready, interface_output, m_out);
            end
        end
        checks++;
        if (delivered < 200) begin
            errors++; $display("FAIL drain_budget: delivered=%0d, need 200", delivered);
        end
        n = 0;
        while ((m_ov || mq.size() > 0) && n < 200) begin
            cyc(0, 0, 0, 1);
            n++;
            checks++;
            if (out_valid !== m_ov || (m_ov && interface_output !== m_out)) begin
                errors++; $display("FAIL flush_%0d: valid=%b/%b word=%h/%h", n, out_valid, m_ov, interface_output, m_out);
            end
        end
        checks++;
        if (buffer_empty !== 1'b1 || count !== 7'd0) begin
            errors++; $display("FAIL flush_empty: empty=%b count=%0d, need 1 0", buffer_empty, count);
        end
    endtask
    task automatic test_reset_mid;
        do_reset();
        repeat (23) cyc(1, 0, $urandom, 0);
        checks++;
        if (count !== 7'd10 || out_valid !== 1'b1) begin
            errors++; $display("FAIL mid_setup: count=%0d valid=%b, need 10 1", count, out_valid);
        end
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || count !== 7'd0 || buffer_empty !== 1'b1) begin
            errors++; $display("FAIL mid_reset: valid=%b count=%0d empty=%b, need 0 0 1", out_valid, count, buffer_empty);
        end
        cyc(1, 0, 32'h5, 1);
        cyc(1, 0, 32'h6, 1);
        cyc(0, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b1 || interface_output !== 64'h00000006_00000005) begin
            errors++; $display("FAIL mid_fresh: valid=%b out=%h, need 1 0000000600000005", out_valid, interface_output);
        end
    endtask
    initial begin
        test_reset();
        test_pair();
        test_odd();
        test_fill();
        test_full_pop();
        test_drain();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
